// File: rtl/tas_pkg.sv
// Shared types, header defaults and the averaging helper used by the
// packet averager and its testbench model.
package tas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2
  } tas_state_e;

  localparam logic [7:0] HDR_A_DEF = 8'hA5;
  localparam logic [7:0] HDR_B_DEF = 8'hC3;

  // The result never exceeds the sample range, so the caller keeps the low DATA_W bits.
  function automatic logic [31:0] avg_calc(input logic [31:0] sum, input logic round,
                                           input int unsigned log2);
    logic [31:0] s;
    s = sum;
    if (round) s = s + (32'd1 << (log2 - 1));
    return s >> log2;
  endfunction

endpackage

// File: rtl/tas_addr_ctr.sv
// Wrapping RAM address counter; counts down from all-ones or up from zero,
// advancing by one on each step pulse.
module tas_addr_ctr #(
  parameter int ADDR_W = 11,
  parameter int DOWN   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] START = (DOWN != 0) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (step_i) addr_d = (DOWN != 0) ? addr_q - 1'b1 : addr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) addr_q <= START;
    else       addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/tas_pkt_avg.sv
// Packet averager: hunts for a header byte, sums the 2**SAMPLES_LOG2 bytes
// that follow and writes their average to the sample RAM.
module tas_pkt_avg
  import tas_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         SAMPLES_LOG2 = 2,
  parameter int         ADDR_W       = 11,
  parameter logic [7:0] HDR_A        = HDR_A_DEF,
  parameter logic [7:0] HDR_B        = HDR_B_DEF,
  parameter int         ROUND        = 0,
  parameter int         ADDR_DOWN    = 1,
  parameter int         TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              pkt_abort,
  output logic              busy
);

  localparam int SUM_W  = DATA_W + SAMPLES_LOG2 + 1;
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [DATA_W-1:0]       HA        = DATA_W'(HDR_A);
  localparam logic [DATA_W-1:0]       HB        = DATA_W'(HDR_B);
  localparam logic [SAMPLES_LOG2-1:0] CNT_LAST  = {SAMPLES_LOG2{1'b1}};
  localparam logic [IDLE_W-1:0]       IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  tas_state_e              state_q, state_d;
  logic [SUM_W-1:0]        sum_q, sum_d, sum_add;
  logic [SAMPLES_LOG2-1:0] cnt_q, cnt_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic                    in_ready_q, in_ready_d;
  logic                    wr_n_q, wr_n_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    abort_q, abort_d;
  logic                    busy_q, busy_d;
  logic                    step;
  logic                    xfer;
  logic [31:0]             avg_full;
  logic                    unused_avg_hi;

  assign xfer     = in_valid && in_ready_q;
  assign sum_add  = sum_q + SUM_W'(in_data);
  assign avg_full = avg_calc(32'(sum_add), ROUND != 0, SAMPLES_LOG2);
  assign unused_avg_hi = ^avg_full[31:DATA_W];

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    wr_n_d  = 1'b1;
    data_d  = data_q;
    abort_d = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer && (in_data == HA || in_data == HB)) begin
          state_d = ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end
      end
      ACCUM: begin
        if (xfer) begin
          sum_d  = sum_add;
          cnt_d  = cnt_q + 1'b1;
          idle_d = '0;
          // Last sample: the average of the running sum including this byte goes out next cycle.
          if (cnt_q == CNT_LAST) begin
            state_d = WRITE;
            wr_n_d  = 1'b0;
            data_d  = avg_full[DATA_W-1:0];
          end
        end else begin
          idle_d = idle_q + 1'b1;
          if (TIMEOUT != 0 && idle_q == IDLE_LAST) begin
            state_d = IDLE;
            abort_d = 1'b1;
            idle_d  = '0;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        step    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d != WRITE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      in_ready_q <= 1'b1;
      wr_n_q     <= 1'b1;
      data_q     <= '0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      in_ready_q <= in_ready_d;
      wr_n_q     <= wr_n_d;
      data_q     <= data_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end

  tas_addr_ctr #(
    .ADDR_W (ADDR_W),
    .DOWN   (ADDR_DOWN)
  ) u_addr (
    .clk_i  (clk),
    .rst_i  (reset),
    .step_i (step),
    .addr_o (ram_addr)
  );

  assign in_ready  = in_ready_q;
  assign ram_wr_n  = wr_n_q;
  assign ram_data  = data_q;
  assign pkt_abort = abort_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tas_pkt_avg.sv
// Directed bench for tas_pkt_avg: several configured instances, expected
// writes queued by the stimulus and checked by a write monitor.
module tb_tas_pkt_avg;
  import tas_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [7:0]  din [4];
  logic        vld [4];
  logic        rdy [4];
  logic        wrn [4];
  logic [7:0]  dout [4];
  logic        abrt [4];
  logic        bsy [4];
  logic [10:0] a0, a1;
  logic [2:0]  a2, a3;
  logic [11:0] dinw, doutw;
  logic        vldw, rdyw, wrnw, abrtw, bsyw;
  logic [10:0] aw;

  tas_pkt_avg u0 (.clk(clk), .reset(reset), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .ram_wr_n(wrn[0]), .ram_data(dout[0]), .ram_addr(a0), .pkt_abort(abrt[0]), .busy(bsy[0]));
  tas_pkt_avg #(.ROUND(1), .TIMEOUT(8)) u1 (.clk(clk), .reset(reset), .in_data(din[1]),
    .in_valid(vld[1]), .in_ready(rdy[1]), .ram_wr_n(wrn[1]), .ram_data(dout[1]), .ram_addr(a1),
    .pkt_abort(abrt[1]), .busy(bsy[1]));
  tas_pkt_avg #(.ADDR_W(3), .ADDR_DOWN(1)) u2 (.clk(clk), .reset(reset), .in_data(din[2]),
    .in_valid(vld[2]), .in_ready(rdy[2]), .ram_wr_n(wrn[2]), .ram_data(dout[2]), .ram_addr(a2),
    .pkt_abort(abrt[2]), .busy(bsy[2]));
  tas_pkt_avg #(.ADDR_W(3), .ADDR_DOWN(0)) u3 (.clk(clk), .reset(reset), .in_data(din[3]),
    .in_valid(vld[3]), .in_ready(rdy[3]), .ram_wr_n(wrn[3]), .ram_data(dout[3]), .ram_addr(a3),
    .pkt_abort(abrt[3]), .busy(bsy[3]));
  tas_pkt_avg #(.DATA_W(12), .SAMPLES_LOG2(3)) uw (.clk(clk), .reset(reset), .in_data(dinw),
    .in_valid(vldw), .in_ready(rdyw), .ram_wr_n(wrnw), .ram_data(doutw), .ram_addr(aw),
    .pkt_abort(abrtw), .busy(bsyw));

  typedef struct {
    int          dut;
    logic [11:0] data;
    logic [10:0] addr;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   abort_cnt [5];
  logic prev_wn [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [11:0] d, input logic [10:0] a);
    exp_t e;
    e.dut = k; e.data = d; e.addr = a;
    expq.push_back(e);
  endtask

  task automatic mon(input int k, input logic wn, input logic [11:0] d, input logic [10:0] a);
    exp_t e;
    if (wn === 1'b0) begin
      if (prev_wn[k] === 1'b0) begin
        n_cmp++; n_err++;
        $display("FAIL wr_n_width_dut%0d: low for 2+ cycles, required 1", k);
      end
      if (expq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write_dut%0d: data %0h addr %0h, required no write", k, d, a);
      end else begin
        e = expq.pop_front();
        check($sformatf("wr_dut%0d_id", k), 32'(k), 32'(e.dut));
        check($sformatf("wr_dut%0d_data", k), 32'(d), 32'(e.data));
        check($sformatf("wr_dut%0d_addr", k), 32'(a), 32'(e.addr));
      end
    end
    prev_wn[k] = wn;
  endtask

  always @(negedge clk) begin
    mon(0, wrn[0], {4'b0, dout[0]}, a0);
    mon(1, wrn[1], {4'b0, dout[1]}, a1);
    mon(2, wrn[2], {4'b0, dout[2]}, {8'b0, a2});
    mon(3, wrn[3], {4'b0, dout[3]}, {8'b0, a3});
    mon(4, wrnw, doutw, aw);
    for (int k = 0; k < 4; k++) abort_cnt[k] += int'(abrt[k]);
    abort_cnt[4] += int'(abrtw);
  end

  task automatic send8(input int k, input logic [7:0] b);
    int tries;
    tries = 0;
    @(negedge clk);
    din[k] = b; vld[k] = 1'b1;
    while (!rdy[k] && tries < 8) begin @(negedge clk); tries++; end
    if (!rdy[k]) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_dut%0d: in_ready stuck low, required high", k);
    end
    @(posedge clk);
  endtask

  task automatic stop8(input int k);
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic pkt8(input int k, input logic [7:0] h, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3,
                      input logic [11:0] ed, input logic [10:0] ea);
    push(k, ed, ea);
    send8(k, h); send8(k, b0); send8(k, b1); send8(k, b2); send8(k, b3);
    stop8(k);
  endtask

  task automatic send12(input logic [11:0] b);
    int tries;
    tries = 0;
    @(negedge clk);
    dinw = b; vldw = 1'b1;
    while (!rdyw && tries < 8) begin @(negedge clk); tries++; end
    if (!rdyw) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_dutw: in_ready stuck low, required high");
    end
    @(posedge clk);
  endtask

  initial begin
    int w;
    logic [7:0] d;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin din[k] = '0; vld[k] = 1'b0; end
    for (int k = 0; k < 5; k++) begin abort_cnt[k] = 0; prev_wn[k] = 1'b1; end
    dinw = '0; vldw = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_n", 32'(wrn[0]), 32'd1);
    check("rst_in_ready", 32'(rdy[0]), 32'd1);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_data", 32'(dout[0]), 32'd0);
    check("rst_abort", 32'(abrt[0]), 32'd0);
    check("rst_addr_down11", 32'(a0), 32'h7FF);
    check("rst_addr_down3", 32'(a2), 32'd7);
    check("rst_addr_up3", 32'(a3), 32'd0);
    reset = 1'b0;

    // Basic packet with latency and in_ready checks
    push(0, 12'd25, 11'h7FF);
    send8(0, 8'hA5); send8(0, 8'd10); send8(0, 8'd20); send8(0, 8'd30); send8(0, 8'd40);
    @(negedge clk);
    check("t1_wr_n_low_t1", 32'(wrn[0]), 32'd0);
    check("t1_in_ready_low", 32'(rdy[0]), 32'd0);
    check("t1_busy_write", 32'(bsy[0]), 32'd1);
    vld[0] = 1'b0;
    @(negedge clk);
    check("t1_wr_n_high_t2", 32'(wrn[0]), 32'd1);
    check("t1_in_ready_back", 32'(rdy[0]), 32'd1);
    check("t1_addr_step", 32'(a0), 32'h7FE);
    check("t1_data_hold", 32'(dout[0]), 32'd25);
    pkt8(0, 8'hA5, 8'd1, 8'd2, 8'd3, 8'd4, 12'd2, 11'h7FE);

    // Rounding
    pkt8(0, 8'hC3, 8'd1, 8'd2, 8'd2, 8'd2, 12'd1, 11'h7FD);
    pkt8(1, 8'hC3, 8'd1, 8'd2, 8'd2, 8'd2, 12'd2, 11'h7FF);
    pkt8(0, 8'hA5, 8'd255, 8'd255, 8'd255, 8'd255, 12'd255, 11'h7FC);
    pkt8(1, 8'hA5, 8'd255, 8'd255, 8'd255, 8'd255, 12'd255, 11'h7FE);

    // Header filtering
    send8(0, 8'h00); send8(0, 8'h7F); send8(0, 8'hA4);
    stop8(0);
    @(negedge clk);
    check("t3_busy_idle", 32'(bsy[0]), 32'd0);
    check("t3_addr_kept", 32'(a0), 32'h7FB);
    pkt8(0, 8'hA5, 8'hA5, 8'hC3, 8'hA5, 8'hC3, 12'hB4, 11'h7FB);

    // Timeout
    send8(1, 8'hA5); send8(1, 8'd10); send8(1, 8'd20);
    stop8(1);
    repeat (12) @(negedge clk);
    check("t4_abort_once", 32'(abort_cnt[1]), 32'd1);
    check("t4_busy_after_abort", 32'(bsy[1]), 32'd0);
    check("t4_addr_unchanged", 32'(a1), 32'h7FD);
    check("t4_no_abort_default", 32'(abort_cnt[0]), 32'd0);
    pkt8(1, 8'hA5, 8'd4, 8'd4, 8'd4, 8'd4, 12'd4, 11'h7FD);

    // Address wrap in both directions
    for (int p = 0; p < 9; p++) begin
      d = 8'(p * 3 + 1);
      pkt8(2, 8'hA5, d, d, d, d, {4'b0, d}, 11'(7 - (p % 8)));
      pkt8(3, 8'hC3, d, d, d, d, {4'b0, d}, 11'(p % 8));
    end

    // Wide samples, reset mid-packet
    push(4, 12'h010, 11'h7FF);
    send12(12'h0A5);
    for (int i = 0; i < 8; i++) send12(12'h010);
    @(negedge clk); vldw = 1'b0;
    @(negedge clk);
    check("t6_addr_after_write", 32'(aw), 32'h7FE);
    send12(12'h0C3); send12(12'h100); send12(12'h100); send12(12'h100);
    @(negedge clk);
    vldw = 1'b0;
    check("t6_busy_before_reset", 32'(bsyw), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(bsyw), 32'd0);
    check("t6_rst_in_ready", 32'(rdyw), 32'd1);
    check("t6_rst_wr_n", 32'(wrnw), 32'd1);
    check("t6_rst_data", 32'(doutw), 32'd0);
    check("t6_rst_addr", 32'(aw), 32'h7FF);
    check("t6_rst_abort", 32'(abrtw), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push(4, 12'h800, 11'h7FF);
    send12(12'h0A5);
    for (int i = 0; i < 8; i++) send12(12'h800);
    @(negedge clk); vldw = 1'b0;

    w = 0;
    while (expq.size() != 0 && w < 50) begin @(negedge clk); w++; end
    check("all_writes_seen", 32'(expq.size()), 32'd0);
    check("no_stray_abort_w", 32'(abort_cnt[4]), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
